cpu_ctrl: RTL and testbench

Instruction fetch, decode and sequencing unit that drives `cpu_data` from the opposite side of its control interface. It owns the program counter, drives the program-memory address, decodes each fetched word into the datapath strobes, selects and immediate, and consumes the zero flag for conditional branches. It adds a boot cycle, a halt/wake state and an optional hardware return stack.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/cpu_ctrl_stack.sv | 57 +++++
 rtl/cpu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, mode encodings, states and field offsets for cpu_ctrl
package cpu_pkg;

  // Instruction word layout: {OP, MODE, OPND}
  localparam int MODE_BITS = 2;
  localparam int OP_BITS   = 5;

  // Control opcodes (OP[4]=1); anything else with OP[4]=1 behaves as NOP
  localparam logic [OP_BITS-1:0] OP_NOP  = 5'b10000;
  localparam logic [OP_BITS-1:0] OP_STR  = 5'b10001;
  localparam logic [OP_BITS-1:0] OP_STM  = 5'b10010;
  localparam logic [OP_BITS-1:0] OP_JMP  = 5'b10011;
  localparam logic [OP_BITS-1:0] OP_JZ   = 5'b10100;
  localparam logic [OP_BITS-1:0] OP_JNZ  = 5'b10101;
  localparam logic [OP_BITS-1:0] OP_CALL = 5'b10110;
  localparam logic [OP_BITS-1:0] OP_RET  = 5'b10111;
  localparam logic [OP_BITS-1:0] OP_HLT  = 5'b11000;

  // ALU B-source selects carried in MODE
  localparam logic [MODE_BITS-1:0] B_IMM  = 2'd0;
  localparam logic [MODE_BITS-1:0] B_REG  = 2'd1;
  localparam logic [MODE_BITS-1:0] B_MEM  = 2'd2;
  localparam logic [MODE_BITS-1:0] B_MEMI = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Low bit of the MODE field for a given operand width
  function automatic int mode_lsb(input int width);
    return width;
  endfunction

  // Low bit of the OP field for a given operand width
  function automatic int op_lsb(input int width);
    return width + MODE_BITS;
  endfunction

endpackage

// File: rtl/cpu_ctrl_stack.sv
// rtl/cpu_ctrl_stack.sv - return-address LIFO with push/pop/full/empty for cpu_ctrl
module cpu_ctrl_stack #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] top_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // cnt_q is the number of valid entries; it also indexes the next free slot
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx   = cnt_q[AW-1:0];
  assign top_idx  = cnt_q[AW-1:0] - AW'(1);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_data = mem_q[top_idx];

  // Entry count moves by one on an accepted push or pop; illegal requests are dropped
  always_comb begin
    cnt_d = cnt_q;
    if (push && !full) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // Entry count register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: only entries below cnt_q are ever read
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - fetch/decode/sequencing unit; CPU_CTRL_CALL_STACK_EN builds the return stack
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 5,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int PC_WIDTH       = 8,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IWIDTH+2+WIDTH-1:0] INSTR,
  input  logic                      Z,
  input  logic                      WAKE,
  output logic [PC_WIDTH-1:0]       PROG_ADDR,
  output logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
  output logic                      EN_REG_F,
  output logic [WIDTH-1:0]          D_MEM_ADDR,
  output logic                      D_MEM_ADDR_MODE,
  output logic                      EN_D_MEM,
  output logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
  output logic [WIDTH-1:0]          IMM,
  output logic [IWIDTH-2:0]         ALU_OUT,
  output logic                      EN_ACC,
  output logic                      HALTED,
  output logic                      STACK_ERR
);

  localparam int OP_LSB   = op_lsb(WIDTH);
  localparam int MODE_LSB = mode_lsb(WIDTH);

  logic [IWIDTH-1:0]    op;
  logic [MODE_BITS-1:0] mode;
  logic [WIDTH-1:0]     opnd;
  logic [PC_WIDTH-1:0]  target;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic                 is_ctrl;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                halted_q, halted_d;

`ifdef CPU_CTRL_CALL_STACK_EN
  logic                err_q, err_d;
  logic                stk_push;
  logic                stk_pop;
  logic                stk_full;
  logic                stk_empty;
  logic [PC_WIDTH-1:0] stk_top;
`endif

  assign op      = INSTR[IWIDTH+2+WIDTH-1:OP_LSB];
  assign mode    = INSTR[MODE_LSB+MODE_BITS-1:MODE_LSB];
  assign opnd    = INSTR[WIDTH-1:0];
  assign is_ctrl = op[IWIDTH-1];
  assign pc_inc  = pc_q + PC_WIDTH'(1);

  // Jump targets are the operand zero-extended or truncated to the PC width
  generate
    if (PC_WIDTH <= WIDTH) begin : g_tgt_trunc
      assign target = opnd[PC_WIDTH-1:0];
    end else begin : g_tgt_ext
      assign target = {{(PC_WIDTH-WIDTH){1'b0}}, opnd};
    end
  endgenerate

  // Operand-derived selects pass through in every state
  assign PROG_ADDR       = pc_q;
  assign IMM             = opnd;
  assign D_MEM_ADDR      = opnd;
  assign REG_F_SEL       = opnd[REG_F_SEL_SIZE-1:0];
  assign IN_B_SEL        = mode;
  assign D_MEM_ADDR_MODE = mode[0];
  assign ALU_OUT         = is_ctrl ? '0 : op[IWIDTH-2:0];
  assign HALTED          = halted_q;

  // Decode strobes and next PC/state; every enable stays low outside RUN
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    EN_ACC   = 1'b0;
    EN_REG_F = 1'b0;
    EN_D_MEM = 1'b0;
`ifdef CPU_CTRL_CALL_STACK_EN
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_d = pc_inc;
        if (!is_ctrl) begin
          EN_ACC = 1'b1;
        end else begin
          case (op)
            OP_STR: EN_REG_F = 1'b1;
            OP_STM: EN_D_MEM = 1'b1;
            OP_JMP: pc_d = target;
            OP_JZ:  if (Z)  pc_d = target;
            OP_JNZ: if (!Z) pc_d = target;
`ifdef CPU_CTRL_CALL_STACK_EN
            OP_CALL: begin
              if (stk_full) begin
                // Overflow freezes the PC on the offending CALL
                err_d   = 1'b1;
                pc_d    = pc_q;
                state_d = ST_HALT;
              end else begin
                stk_push = 1'b1;
                pc_d     = target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                err_d   = 1'b1;
                pc_d    = pc_q;
                state_d = ST_HALT;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
`endif
            OP_HLT: state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        if (WAKE) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // Sequencer state, PC and registered status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_BOOT;
      pc_q     <= '0;
      halted_q <= 1'b0;
`ifdef CPU_CTRL_CALL_STACK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
`ifdef CPU_CTRL_CALL_STACK_EN
      err_q    <= err_d;
`endif
    end
  end

`ifdef CPU_CTRL_CALL_STACK_EN
  assign STACK_ERR = err_q;

  // Return stack holds PC+1 of each CALL
  cpu_ctrl_stack #(
    .DEPTH (STACK_DEPTH),
    .DW    (PC_WIDTH)
  ) u_stack (
    .clk       (CLK),
    .rst       (RST),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`else
  assign STACK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl with a combinational program memory
module tb_cpu_ctrl;

  localparam logic [4:0] T_NOP  = 5'b10000;
  localparam logic [4:0] T_STR  = 5'b10001;
  localparam logic [4:0] T_STM  = 5'b10010;
  localparam logic [4:0] T_JMP  = 5'b10011;
  localparam logic [4:0] T_JZ   = 5'b10100;
  localparam logic [4:0] T_JNZ  = 5'b10101;
  localparam logic [4:0] T_CALL = 5'b10110;
  localparam logic [4:0] T_RET  = 5'b10111;
  localparam logic [4:0] T_HLT  = 5'b11000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        z = 1'b0;
  logic        wake = 1'b0;
  logic [14:0] instr;
  logic [7:0]  prog_addr;
  logic [3:0]  reg_f_sel;
  logic        en_reg_f;
  logic [7:0]  d_mem_addr;
  logic        d_mem_addr_mode;
  logic        en_d_mem;
  logic [1:0]  in_b_sel;
  logic [7:0]  imm;
  logic [3:0]  alu_out;
  logic        en_acc;
  logic        halted;
  logic        stack_err;

  logic [14:0] pmem [256];
  assign instr = pmem[prog_addr];

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .CLK             (clk),
    .RST             (rst),
    .INSTR           (instr),
    .Z               (z),
    .WAKE            (wake),
    .PROG_ADDR       (prog_addr),
    .REG_F_SEL       (reg_f_sel),
    .EN_REG_F        (en_reg_f),
    .D_MEM_ADDR      (d_mem_addr),
    .D_MEM_ADDR_MODE (d_mem_addr_mode),
    .EN_D_MEM        (en_d_mem),
    .IN_B_SEL        (in_b_sel),
    .IMM             (imm),
    .ALU_OUT         (alu_out),
    .EN_ACC          (en_acc),
    .HALTED          (halted),
    .STACK_ERR       (stack_err)
  );

  typedef struct {
    string       name;
    logic [39:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_x;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [39:0] act;

  assign act = {prog_addr, halted, stack_err, en_acc, en_reg_f, en_d_mem,
                alu_out, imm, in_b_sel, reg_f_sel, d_mem_addr, d_mem_addr_mode};

  function automatic logic [14:0] w(input logic [4:0] op, input logic [1:0] mode, input logic [7:0] opnd);
    return {op, mode, opnd};
  endfunction

  // en = {EN_ACC, EN_REG_F, EN_D_MEM}; selects follow from the word the bench placed at pa
  task automatic expect_out(input string name, input logic [7:0] pa, input logic h,
                            input logic e, input logic [2:0] en);
    logic [14:0] wd;
    logic [3:0]  alu;
    exp_t        x;
    wd  = pmem[pa];
    alu = wd[14] ? 4'h0 : wd[13:10];
    x.name = name;
    x.v    = {pa, h, e, en, alu, wd[7:0], wd[9:8], wd[3:0], wd[7:0], wd[8]};
    exp_q.push_back(x);
  endtask

  task automatic step(input string name, input logic [7:0] pa, input logic h,
                      input logic e, input logic [2:0] en);
    @(posedge clk);
    #1;
    expect_out(name, pa, h, e, en);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_out("reset", 8'h00, 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("boot", 8'h00, 1'b0, 1'b0, 3'b000);
  endtask

  // Lets the pending check sample before program memory is rewritten
  task automatic load_gap();
    @(negedge clk);
    #1;
  endtask

  // Monitor: one expected output per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      n_checks++;
      if (act === mon_x.v) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %h required %h (pa,h,err,en3,alu,imm,bsel,rsel,daddr,dmode)",
                 mon_x.name, act, mon_x.v);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) pmem[i] = w(T_NOP, 2'd0, 8'h00);
    pmem[8'h04] = w(5'b00010, 2'd0, 8'h5A);
    pmem[8'h05] = w(T_STR,    2'd0, 8'h03);
    pmem[8'h06] = w(T_STM,    2'd1, 8'h33);
    pmem[8'h07] = w(T_JZ,     2'd0, 8'h40);
    pmem[8'h40] = w(T_JZ,     2'd0, 8'h60);
    pmem[8'h41] = w(5'b01111, 2'd3, 8'h11);
    pmem[8'h42] = w(T_JNZ,    2'd2, 8'h80);
    pmem[8'h80] = w(T_JMP,    2'd0, 8'hFF);

    // Boot, sequential fetch, decode strobes, branches and PC wrap
    do_reset();
    step("nop0", 8'h00, 1'b0, 1'b0, 3'b000);
    step("nop1", 8'h01, 1'b0, 1'b0, 3'b000);
    step("nop2", 8'h02, 1'b0, 1'b0, 3'b000);
    step("nop3", 8'h03, 1'b0, 1'b0, 3'b000);
    step("alu_imm", 8'h04, 1'b0, 1'b0, 3'b100);
    step("str", 8'h05, 1'b0, 1'b0, 3'b010);
    step("stm", 8'h06, 1'b0, 1'b0, 3'b001);
    step("jz_z1", 8'h07, 1'b0, 1'b0, 3'b000);
    z = 1'b1;
    step("jz_taken", 8'h40, 1'b0, 1'b0, 3'b000);
    z = 1'b0;
    step("jz_not_taken", 8'h41, 1'b0, 1'b0, 3'b100);
    step("jnz_z0", 8'h42, 1'b0, 1'b0, 3'b000);
    step("jnz_taken", 8'h80, 1'b0, 1'b0, 3'b000);
    step("jmp_ff", 8'hFF, 1'b0, 1'b0, 3'b000);
    step("pc_wrap", 8'h00, 1'b0, 1'b0, 3'b000);

    // HLT, hold, WAKE, then reset in the middle of HALT
    load_gap();
    pmem[8'h00] = w(T_JMP, 2'd0, 8'h10);
    pmem[8'h10] = w(T_HLT, 2'd0, 8'h00);
    pmem[8'h12] = w(T_HLT, 2'd0, 8'h00);
    do_reset();
    step("jmp_10", 8'h00, 1'b0, 1'b0, 3'b000);
    step("hlt", 8'h10, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) step("halt_hold", 8'h11, 1'b1, 1'b0, 3'b000);
    wake = 1'b1;
    step("wake_run", 8'h11, 1'b0, 1'b0, 3'b000);
    step("wake_in_run", 8'h12, 1'b0, 1'b0, 3'b000);
    wake = 1'b0;
    step("halt2", 8'h13, 1'b1, 1'b0, 3'b000);

    // CALL/RET and nested overflow
    load_gap();
    pmem[8'h00] = w(T_JMP,  2'd0, 8'h05);
    pmem[8'h05] = w(T_CALL, 2'd0, 8'h20);
    pmem[8'h20] = w(T_RET,  2'd0, 8'h00);
    pmem[8'h06] = w(T_CALL, 2'd0, 8'h30);
    pmem[8'h30] = w(T_CALL, 2'd0, 8'h31);
    pmem[8'h31] = w(T_CALL, 2'd0, 8'h32);
    pmem[8'h32] = w(T_CALL, 2'd0, 8'h33);
    pmem[8'h33] = w(T_CALL, 2'd0, 8'h34);
    do_reset();
    step("jmp_05", 8'h00, 1'b0, 1'b0, 3'b000);
    step("call", 8'h05, 1'b0, 1'b0, 3'b000);
`ifdef CPU_CTRL_CALL_STACK_EN
    step("call_target", 8'h20, 1'b0, 1'b0, 3'b000);
    step("ret_target", 8'h06, 1'b0, 1'b0, 3'b000);
    step("nest2", 8'h30, 1'b0, 1'b0, 3'b000);
    step("nest3", 8'h31, 1'b0, 1'b0, 3'b000);
    step("nest4", 8'h32, 1'b0, 1'b0, 3'b000);
    step("nest5", 8'h33, 1'b0, 1'b0, 3'b000);
    step("overflow", 8'h33, 1'b1, 1'b1, 3'b000);
    step("overflow_hold", 8'h33, 1'b1, 1'b1, 3'b000);
`else
    step("call_as_nop", 8'h06, 1'b0, 1'b0, 3'b000);
    step("call_as_nop2", 8'h07, 1'b0, 1'b0, 3'b000);
`endif

    // RET on an empty stack; reset also clears any earlier error
    load_gap();
    pmem[8'h00] = w(T_RET, 2'd0, 8'h00);
    do_reset();
    step("ret_empty", 8'h00, 1'b0, 1'b0, 3'b000);
`ifdef CPU_CTRL_CALL_STACK_EN
    step("underflow", 8'h00, 1'b1, 1'b1, 3'b000);
`else
    step("ret_as_nop", 8'h01, 1'b0, 1'b0, 3'b000);
`endif

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
